// File: rtl/riscv_mmio_port_pkg.sv
// riscv_mmio_pkg: default parameters, register offsets and status-bit positions for the MMIO port
package riscv_mmio_pkg;
   localparam int DEF_XLEN       = 32;
   localparam int DEF_NUM_IN     = 1;
   localparam int DEF_NUM_OUT    = 2;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam logic [31:0] DEF_BASE_ADDR = 32'hFFFF_0000;
   localparam logic [7:0] IN_OFS   = 8'h00;
   localparam logic [7:0] OUT_OFS  = 8'h40;
   localparam logic [7:0] STAT_OFS = 8'h80;
   localparam int FULL_BIT  = 0;
   localparam int EMPTY_BIT = 16;
endpackage

// File: rtl/riscv_mmio_port_fifo.sv
// mmio_fifo: output channel queue; head holds the last popped word while empty
module mmio_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
)(
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [WIDTH-1:0] last;
   logic do_push, do_pop;
   assign full    = int'(count) == DEPTH;
   assign empty   = count == '0;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = empty ? last : mem[rp];
   // pointer/count update; a push against a full queue is refused even if a pop happens too
   always_ff @(posedge CLK) begin
      if (Reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
         last  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wp] <= din;
            wp      <= wp + 1'b1;
         end
         if (do_pop) begin
            last <= mem[rp];
            rp   <= rp + 1'b1;
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/riscv_mmio_port.sv
// riscv_mmio_port: 256-byte MMIO window with sampled input registers, output FIFOs and a status word
module riscv_mmio_port
   import riscv_mmio_pkg::*;
#(
   parameter int XLEN = DEF_XLEN,
   parameter int NUM_IN = DEF_NUM_IN,
   parameter int NUM_OUT = DEF_NUM_OUT,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter logic [XLEN-1:0] BASE_ADDR = DEF_BASE_ADDR
)(
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic [XLEN-1:0]          Addr,
   input  logic [XLEN-1:0]          WD,
   input  logic                     WE,
   input  logic                     RE,
   output logic [XLEN-1:0]          RD,
   output logic                     Stall,
   input  logic [NUM_IN*XLEN-1:0]   CPUIn,
   output logic [NUM_OUT*XLEN-1:0]  CPUOut,
   output logic [NUM_OUT-1:0]       OutValid,
   input  logic [NUM_OUT-1:0]       OutReady
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic [XLEN-1:0] in_reg [NUM_IN];
   logic [CW-1:0] cnt [NUM_OUT];
   logic [NUM_OUT-1:0] full, empty, hit, stall_v;
   logic win;
   logic [7:0] ofs;
   assign win   = Addr[XLEN-1:8] == BASE_ADDR[XLEN-1:8];
   assign ofs   = Addr[7:0];
   assign Stall = |stall_v & ~Reset;
   // input registers follow the external channels with one cycle of latency
   always_ff @(posedge CLK) begin
      for (int i = 0; i < NUM_IN; i++) in_reg[i] <= Reset ? '0 : CPUIn[i*XLEN +: XLEN];
   end
   for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
      assign hit[j]      = win && ofs == OUT_OFS + 8'(4*j);
      assign stall_v[j]  = WE && hit[j] && full[j];
      assign OutValid[j] = ~empty[j];
      mmio_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
         .CLK(CLK),
         .Reset(Reset),
         .push(WE && hit[j]),
         .pop(OutReady[j]),
         .din(WD),
         .full(full[j]),
         .empty(empty[j]),
         .count(cnt[j]),
         .head(CPUOut[j*XLEN +: XLEN])
      );
   end
   // load mux; anything outside the mapped registers reads as zero
   always_comb begin
      RD = '0;
      if (RE && win) begin
         if (ofs == STAT_OFS) begin
            for (int j = 0; j < NUM_OUT; j++) begin
               RD[FULL_BIT+j]  = full[j];
               RD[EMPTY_BIT+j] = empty[j];
            end
         end
         for (int i = 0; i < NUM_IN; i++) if (ofs == IN_OFS + 8'(4*i)) RD = in_reg[i];
         for (int j = 0; j < NUM_OUT; j++) if (hit[j]) RD = XLEN'(cnt[j]);
      end
   end
endmodule

// File: tb/tb_riscv_mmio_port.sv
// tb_riscv_mmio_port: directed and randomized checks of the MMIO port against a queue-based model
module tb_riscv_mmio_port;
   logic CLK = 1'b0;
   logic Reset, WE, RE, Stall;
   logic [31:0] Addr, WD, RD;
   logic [63:0] CPUIn, CPUOut;
   logic [1:0] OutValid, OutReady;
   int n_cmp = 0, n_bad = 0;
   logic [31:0] q0[$], q1[$];
   logic [31:0] last [2];
   logic [31:0] inr [2];

   always #5 CLK = ~CLK;

   riscv_mmio_port #(.NUM_IN(2)) dut (
      .CLK(CLK), .Reset(Reset), .Addr(Addr), .WD(WD), .WE(WE), .RE(RE), .RD(RD),
      .Stall(Stall), .CPUIn(CPUIn), .CPUOut(CPUOut), .OutValid(OutValid), .OutReady(OutReady)
   );

   function automatic int sz(int j);
      return j == 0 ? q0.size() : q1.size();
   endfunction

   function automatic logic [31:0] front(int j);
      return j == 0 ? q0[0] : q1[0];
   endfunction

   function automatic int fifo_hit();
      if (Addr == 32'hFFFF_0040) return 0;
      if (Addr == 32'hFFFF_0044) return 1;
      return -1;
   endfunction

   function automatic logic [31:0] exp_rd();
      logic [31:0] r = '0;
      if (!RE || Addr[31:8] != 24'hFFFF00) return '0;
      case (Addr[7:0])
         8'h00: r = inr[0];
         8'h04: r = inr[1];
         8'h40: r = 32'(sz(0));
         8'h44: r = 32'(sz(1));
         8'h80: begin
            r[0]  = sz(0) == 4;
            r[1]  = sz(1) == 4;
            r[16] = sz(0) == 0;
            r[17] = sz(1) == 0;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic chk();
      int h;
      @(negedge CLK);
      h = fifo_hit();
      cmp("stall", Stall, !Reset && WE && h >= 0 && sz(h) == 4);
      if (!Reset) begin
         cmp("rd", RD, exp_rd());
         for (int j = 0; j < 2; j++) begin
            cmp("valid", OutValid[j], sz(j) != 0);
            cmp("cpuout", CPUOut[j*32 +: 32], sz(j) != 0 ? front(j) : last[j]);
         end
      end
   endtask

   task automatic adv();
      int h;
      bit pu [2];
      bit po [2];
      @(posedge CLK);
      if (Reset) begin
         q0.delete();
         q1.delete();
         last = '{32'h0, 32'h0};
         inr  = '{32'h0, 32'h0};
      end else begin
         h = fifo_hit();
         for (int j = 0; j < 2; j++) begin
            po[j] = sz(j) != 0 && OutReady[j];
            pu[j] = WE && h == j && sz(j) < 4;
         end
         inr[0] = CPUIn[31:0];
         inr[1] = CPUIn[63:32];
         if (po[0]) last[0] = q0.pop_front();
         if (po[1]) last[1] = q1.pop_front();
         if (pu[0]) q0.push_back(WD);
         if (pu[1]) q1.push_back(WD);
      end
      #1;
   endtask

   initial begin
      int sel, thr;
      logic [31:0] vals [4];
      Reset = 1'b1; WE = 1'b0; RE = 1'b0; Addr = '0; WD = '0; CPUIn = '0; OutReady = '0;
      repeat (2) begin chk(); adv(); end
      Reset = 1'b0;
      RE = 1'b1; Addr = 32'hFFFF_0080;
      chk(); cmp("status_after_reset", RD, 32'h0003_0000); cmp("valid_after_reset", OutValid, 2'b00); adv();
      CPUIn = 64'd131; Addr = 32'hFFFF_0000;
      chk(); adv();
      chk(); cmp("in0_latency", RD, 32'd131); adv();
      RE = 1'b0; WE = 1'b1; Addr = 32'hFFFF_0040;
      vals = '{32'hA, 32'hB, 32'hC, 32'hD};
      for (int k = 0; k < 4; k++) begin WD = vals[k]; chk(); adv(); end
      WE = 1'b0; RE = 1'b1;
      chk(); cmp("count_full", RD, 32'd4); adv();
      Addr = 32'hFFFF_0080;
      chk(); cmp("status_full", RD, 32'h0002_0001); adv();
      Addr = 32'hFFFF_0040; WE = 1'b1; RE = 1'b0; WD = 32'hE;
      chk(); cmp("stall_full", Stall, 1'b1); adv();
      WE = 1'b0; RE = 1'b1;
      chk(); cmp("count_after_stall", RD, 32'd4); adv();
      RE = 1'b0; OutReady = 2'b01;
      for (int k = 0; k < 4; k++) begin chk(); cmp("pop_order", CPUOut[31:0], vals[k]); adv(); end
      OutReady = 2'b00;
      chk(); cmp("valid_drained", OutValid[0], 1'b0); cmp("hold_last", CPUOut[31:0], 32'hD); adv();
      WE = 1'b1; Addr = 32'hFFFF_0044;
      WD = 32'h11; chk(); adv();
      WD = 32'h22; chk(); adv();
      WD = 32'h33; OutReady = 2'b10;
      chk(); cmp("head1_pushpop", CPUOut[63:32], 32'h11); adv();
      WE = 1'b0; RE = 1'b1; OutReady = 2'b00;
      chk(); cmp("count1_same", RD, 32'd2); cmp("head1_next", CPUOut[63:32], 32'h22); cmp("fifo0_idle", OutValid[0], 1'b0); adv();
      RE = 1'b0; OutReady = 2'b10;
      chk(); cmp("fifo1_order_a", CPUOut[63:32], 32'h22); adv();
      chk(); cmp("fifo1_order_b", CPUOut[63:32], 32'h33); adv();
      OutReady = 2'b00; WE = 1'b1; Addr = 32'hFFFF_0040;
      for (int k = 1; k <= 3; k++) begin WD = 32'(k); chk(); adv(); end
      WE = 1'b0; Reset = 1'b1;
      chk(); adv();
      Reset = 1'b0; RE = 1'b1;
      chk(); cmp("rst_valid", OutValid, 2'b00); cmp("rst_count", RD, 32'd0); cmp("rst_cpuout", CPUOut, 64'd0); adv();
      for (int c = 0; c < 3000; c++) begin
         thr = ((c / 64) % 2) != 0 ? 1 : 5;
         Reset = $urandom_range(0, 199) == 0;
         WE = $urandom_range(0, 2) != 0;
         RE = $urandom_range(0, 1) != 0;
         WD = $urandom;
         CPUIn = {$urandom, $urandom};
         OutReady = {$urandom_range(0, 9) < thr, $urandom_range(0, 9) < thr};
         sel = $urandom_range(0, 11);
         if (sel < 4) Addr = 32'hFFFF_0040;
         else if (sel < 8) Addr = 32'hFFFF_0044;
         else if (sel == 8) Addr = 32'hFFFF_0000;
         else if (sel == 9) Addr = 32'hFFFF_0004;
         else if (sel == 10) Addr = 32'hFFFF_0080;
         else begin
            case ($urandom_range(0, 5))
               0: Addr = 32'hFFFF_0008;
               1: Addr = 32'hFFFF_0048;
               2: Addr = 32'hFFFF_0084;
               3: Addr = 32'hFFFF_0041;
               4: Addr = 32'hFFFE_0040;
               default: Addr = $urandom;
            endcase
         end
         chk(); adv();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
